// File: rtl/dmem_req_ctrl_pkg.sv
// Shared definitions for the data-memory request controller:
// FSM state encoding and bus transfer size codes.
package dmem_req_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/dmem_req_ctrl.sv
// M-stage data-memory request controller: issues one bus
// transaction per memory op and stalls the pipe until data returns.
module dmem_req_ctrl
   import dmem_req_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_flush,
   input  logic        other_stall,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   state_e      state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req_c;
   logic        stall_c;
   logic [31:0] rdata_c;

   // State, request holding registers and load result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next state, request capture, bus drive and stall generation.
   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      req_c      = 1'b0;
      stall_c    = 1'b0;
      rdata_c    = rdata_q;
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (mem_req && !mem_flush) begin
               // First cycle goes straight from the pipe to the bus.
               req_c      = 1'b1;
               stall_c    = 1'b1;
               data_wr    = mem_wr;
               data_size  = mem_size;
               data_addr  = mem_addr;
               data_wdata = mem_wdata;
               wr_d       = mem_wr;
               size_d     = mem_size;
               addr_d     = mem_addr;
               wdata_d    = mem_wdata;
               state_d    = data_addr_ok ? S_DATA : S_ADDR;
            end
         end
         S_ADDR: begin
            // data_ok here is ignored; only the address accept counts.
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (data_addr_ok) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            stall_c = !data_data_ok;
            if (data_data_ok) begin
               rdata_d = data_rdata;
               rdata_c = data_rdata;
               state_d = other_stall ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            // Park until the pipe moves so the op is not reissued.
            if (!other_stall) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held.
   always_comb begin
      data_req  = req_c && !rst;
      mem_stall = stall_c && !rst;
      mem_rdata = rst ? 32'd0 : rdata_c;
   end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: per-cycle vector table
// plus hand-written multi-cycle sequences.
module tb_dmem_req_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_flush;
   logic        other_stall;
   logic        mem_stall;
   logic [31:0] mem_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int checks = 0;
   int errors = 0;

   dmem_req_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_size    (mem_size),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_flush   (mem_flush),
      .other_stall (other_stall),
      .mem_stall   (mem_stall),
      .mem_rdata   (mem_rdata),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_size   (data_size),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .data_rdata  (data_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        flush;
      logic        ost;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
   } in_t;

   typedef struct {
      logic        stall;
      logic [31:0] rdata;
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   vec_t vecs[$];

   function automatic in_t mi(
      logic r, logic q, logic w, logic [1:0] s,
      logic [31:0] a, logic [31:0] wd, logic f,
      logic os, logic ao, logic dk, logic [31:0] rd);
      in_t t;
      t.rst = r;   t.req = q;  t.wr = w;
      t.size = s;  t.addr = a; t.wdata = wd;
      t.flush = f; t.ost = os; t.aok = ao;
      t.dok = dk;  t.rdata = rd;
      return t;
   endfunction

   function automatic exp_t me(
      logic st, logic [31:0] rd, logic q, logic w,
      logic [1:0] s, logic [31:0] a, logic [31:0] wd);
      exp_t t;
      t.stall = st; t.rdata = rd; t.req = q;
      t.wr = w; t.size = s; t.addr = a; t.wdata = wd;
      return t;
   endfunction

   function automatic exp_t mq(logic st, logic [31:0] rd);
      return me(st, rd, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
   endfunction

   task automatic apply(input in_t t);
      rst          = t.rst;
      mem_req      = t.req;
      mem_wr       = t.wr;
      mem_size     = t.size;
      mem_addr     = t.addr;
      mem_wdata    = t.wdata;
      mem_flush    = t.flush;
      other_stall  = t.ost;
      data_addr_ok = t.aok;
      data_data_ok = t.dok;
      data_rdata   = t.rdata;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      apply(mi(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0));
   endtask

   initial begin
      int cnt;
      int waited;
      logic seen_ok;

      // reset with a pending request: outputs must stay quiet
      vecs.push_back('{mi(1,1,0,2'd2,32'h100,0,0,0,1,1,32'h1),
                       mq(0, 32'h0)});
      // load word 0x100, addr_ok same cycle, data_ok two cycles on
      vecs.push_back('{mi(0,1,0,2'd2,32'h100,0,0,0,1,0,0),
                       me(1,32'h0,1,0,2'd2,32'h100,0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h100,0,0,0,0,0,0),
                       mq(1, 32'h0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h100,0,0,0,0,1,32'hDEADBEEF),
                       mq(0, 32'hDEADBEEF)});
      // data_ok while idle is ignored
      vecs.push_back('{mi(0,0,0,2'd0,0,0,0,0,0,1,32'h11111111),
                       mq(0, 32'hDEADBEEF)});
      // store byte 0x103, accept after 3 cycles, inputs wiggle meanwhile
      vecs.push_back('{mi(0,1,1,2'd0,32'h103,32'hABABABAB,0,0,0,0,0),
                       me(1,32'hDEADBEEF,1,1,2'd0,32'h103,32'hABABABAB)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h555,32'h0,0,0,0,0,0),
                       me(1,32'hDEADBEEF,1,1,2'd0,32'h103,32'hABABABAB)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h555,32'h0,0,0,0,1,32'h77),
                       me(1,32'hDEADBEEF,1,1,2'd0,32'h103,32'hABABABAB)});
      // addr_ok and data_ok together in ADDR: only addr_ok honoured
      vecs.push_back('{mi(0,1,1,2'd0,32'h103,32'hABABABAB,0,0,1,1,32'h12345678),
                       me(1,32'hDEADBEEF,1,1,2'd0,32'h103,32'hABABABAB)});
      vecs.push_back('{mi(0,1,1,2'd0,32'h103,32'hABABABAB,0,0,0,0,0),
                       mq(1, 32'hDEADBEEF)});
      vecs.push_back('{mi(0,1,1,2'd0,32'h103,32'hABABABAB,0,0,0,1,32'hCAFE),
                       mq(0, 32'hCAFE)});
      // other_stall held across data_ok: DONE, no reissue
      vecs.push_back('{mi(0,1,0,2'd2,32'h40,0,0,1,1,0,0),
                       me(1,32'hCAFE,1,0,2'd2,32'h40,0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h40,0,0,1,0,1,32'h5A5A1234),
                       mq(0, 32'h5A5A1234)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h40,0,0,1,1,1,32'hFFFF),
                       mq(0, 32'h5A5A1234)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h40,0,0,1,1,1,32'hFFFF),
                       mq(0, 32'h5A5A1234)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h40,0,0,0,1,1,32'hFFFF),
                       mq(0, 32'h5A5A1234)});
      vecs.push_back('{mi(0,0,0,2'd0,0,0,0,0,0,0,0),
                       mq(0, 32'h5A5A1234)});
      // flush blocks issue from IDLE
      vecs.push_back('{mi(0,1,0,2'd2,32'h80,0,1,0,1,0,0),
                       mq(0, 32'h5A5A1234)});
      // flush during DATA: transaction still completes
      vecs.push_back('{mi(0,1,0,2'd2,32'h80,0,0,0,1,0,0),
                       me(1,32'h5A5A1234,1,0,2'd2,32'h80,0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h80,0,1,0,0,0,0),
                       mq(1, 32'h5A5A1234)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h80,0,1,0,0,1,32'h0BADF00D),
                       mq(0, 32'h0BADF00D)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h80,0,1,0,1,0,0),
                       mq(0, 32'h0BADF00D)});
      // reset in DATA abandons the cycle; fresh load completes
      vecs.push_back('{mi(0,1,0,2'd2,32'h300,0,0,0,1,0,0),
                       me(1,32'h0BADF00D,1,0,2'd2,32'h300,0)});
      vecs.push_back('{mi(1,1,0,2'd2,32'h300,0,0,0,0,1,32'h99),
                       mq(0, 32'h0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h304,0,0,0,0,0,0),
                       me(1,32'h0,1,0,2'd2,32'h304,0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h304,0,0,0,1,0,0),
                       me(1,32'h0,1,0,2'd2,32'h304,0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h304,0,0,0,0,1,32'h600DCAFE),
                       mq(0, 32'h600DCAFE)});
      // back-to-back: store half 0x202 then load word 0x200
      vecs.push_back('{mi(0,1,1,2'd1,32'h202,32'hBEEFBEEF,0,0,1,0,0),
                       me(1,32'h600DCAFE,1,1,2'd1,32'h202,32'hBEEFBEEF)});
      vecs.push_back('{mi(0,1,1,2'd1,32'h202,32'hBEEFBEEF,0,0,0,1,32'h0),
                       mq(0, 32'h0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h200,0,0,0,1,0,0),
                       me(1,32'h0,1,0,2'd2,32'h200,0)});
      vecs.push_back('{mi(0,1,0,2'd2,32'h200,0,0,0,0,1,32'h13579BDF),
                       mq(0, 32'h13579BDF)});

      apply(vecs[0].i);
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         apply(vecs[k].i);
         #1;
         chk($sformatf("v%0d stall", k), 32'(mem_stall),
             32'(vecs[k].e.stall));
         chk($sformatf("v%0d rdata", k), mem_rdata, vecs[k].e.rdata);
         chk($sformatf("v%0d req", k), 32'(data_req),
             32'(vecs[k].e.req));
         if (vecs[k].e.req) begin
            chk($sformatf("v%0d wr", k), 32'(data_wr),
                32'(vecs[k].e.wr));
            chk($sformatf("v%0d size", k), 32'(data_size),
                32'(vecs[k].e.size));
            chk($sformatf("v%0d addr", k), data_addr, vecs[k].e.addr);
            chk($sformatf("v%0d wdata", k), data_wdata,
                vecs[k].e.wdata);
         end
      end

      // drain to idle
      @(negedge clk);
      idle_in();
      @(negedge clk);

      // count consecutive request cycles for a late-accepted store
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         apply(mi(0,1,1,2'd0,32'h103,32'h5C5C5C5C,0,0,
                  (c == 3),0,0));
         #1;
         if (data_req) begin
            cnt++;
            chk("seq addr", data_addr, 32'h103);
            chk("seq size", 32'(data_size), 32'd0);
            chk("seq wr", 32'(data_wr), 32'd1);
         end
         @(negedge clk);
         if (c == 3) break;
      end
      chk("seq req cycles", 32'(cnt), 32'd4);
      // wait (bounded) for data phase to finish
      seen_ok = 1'b0;
      waited = 0;
      while (!seen_ok && waited < 10) begin
         apply(mi(0,1,1,2'd0,32'h103,32'h5C5C5C5C,0,0,0,
                  (waited == 2),32'h2468ACE0));
         #1;
         chk("seq no reissue", 32'(data_req), 32'd0);
         if (!mem_stall) seen_ok = 1'b1;
         @(negedge clk);
         waited++;
      end
      chk("seq data_ok timeout", 32'(seen_ok), 32'd1);
      chk("seq rdata", mem_rdata, 32'h2468ACE0);

      // async reset mid-cycle while waiting in ADDR
      apply(mi(0,1,0,2'd2,32'h400,0,0,0,0,0,0));
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst req", 32'(data_req), 32'd0);
      chk("async rst stall", 32'(mem_stall), 32'd0);
      chk("async rst rdata", mem_rdata, 32'd0);
      @(negedge clk);
      idle_in();
      #1;
      chk("post rst no drain", 32'(data_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
